term_writer: RTL and testbench
==============================

# term_writer

Terminal write controller between the UART receive path and the text-mode character RAM read by the VGA text generator. Takes received bytes with their one-cycle strobe and buffers them in a small FIFO. Interprets printable ASCII and control codes, maintains a cursor, and issues single-cycle writes (address, character) into the 80×30 character RAM. Sits directly downstream of the UART receiver and upstream of the text generation circuit's write port.

## Interface
- COLS, 80, characters per row (640 px / 8)
- ROWS, 30, character rows (480 px / 16)
- FIFO_DEPTH, 4, input byte FIFO entries (power of two)
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe from UART receiver
- wr_en  out  1  one-cycle character RAM write strobe
- wr_addr  out  12  RAM address = row*COLS + col
- wr_char  out  7  ASCII code to write
- cursor_row  out  5  current cursor row
- cursor_col  out  7  current cursor column
- busy  out  1  high while FSM is not in IDLE
- overflow  out  1  sticky: byte dropped on full FIFO

## Operation
- Reset (async) clears FIFO, state=IDLE, cursor (0,0); all outputs 0.
- FIFO push on rx_valid when not full, or when full with a pop in the same cycle. Otherwise the byte is dropped and overflow is set. overflow is cleared only by reset.
- FSM states: IDLE, WRITE, CLEAR.
- IDLE: if FIFO non-empty, pop and decode in the same cycle:
  - 0x20–0x7E: go to WRITE with char=rx[6:0] at the cursor.
  - 0x0D (CR): col←0, stay IDLE.
  - 0x0A (LF): col←0, then line advance.
  - 0x08 (BS): if col>0, col←col−1 and go to WRITE with 0x20 at the new position. If col=0, no action.
  - 0x0C (FF): cursor←(0,0); go to CLEAR over addresses 0..COLS*ROWS−1.
  - All other bytes: discarded, no action.
- WRITE (1 cycle): wr_en=1 with the addr/char latched at decode, then return to IDLE.
  - Printable characters advance col.
  - If col reaches COLS, col←0 and line advance.
  - BS does not advance.
- Line advance: row←(row==ROWS−1) ? 0 : row+1. There is no scrolling; the screen wraps to the top.
- CLEAR: one write of 0x20 per cycle, address counter from start to end inclusive; return to IDLE after the last write. FIFO continues accepting bytes but nothing is popped.

## Timing
- rx_valid in cycle t → entry visible in cycle t+1 → popped/decoded in t+1 (if IDLE) → wr_en high in cycle t+2.
- Back-to-back printable bytes: one write every 2 cycles (IDLE, WRITE). Sustained rate ≫ UART byte rate.
- Cursor outputs update on the clock edge ending the WRITE or control-code cycle.
- Full-screen clear takes COLS*ROWS = 2400 cycles of wr_en; row clear takes COLS = 80 cycles.
- Reset asserted mid-CLEAR or mid-WRITE: immediate return to IDLE, wr_en 0 with no partial write, FIFO emptied. RAM contents are not restored.
- wr_addr and wr_char hold their last value when wr_en=0.

## Configuration
- TERM_ROWCLEAR_EN defined: every line advance (LF or column wrap) enters CLEAR for the new row. This writes 0x20 to addresses row*COLS..row*COLS+COLS−1, and the cursor is at (row,0) afterwards.
- Undefined: line advance only moves the cursor. Old row contents remain until overwritten. No CLEAR entry except on FF.

## Structure
- Package term_pkg holds:
  - Default COLS/ROWS.
  - ASCII constants CHR_BS, CHR_LF, CHR_FF, CHR_CR, CHR_SPACE, CHR_PRINT_LO/HI.
  - State enum (IDLE, WRITE, CLEAR).
  - ADDR_W=12 constant.
- Sub-module byte_fifo: synchronous FIFO with parameterised depth, push/pop/full/empty, and same-cycle push+pop when full. Async active-high reset on clk/reset.
- Cursor, address arithmetic and FSM live in term_writer. The address is computed as row*80 + col using shifts ((row<<6)+(row<<4)+col), 12 bits, with no overflow for ROWS≤30.

## Test plan
- Reset, then send 'H','i' (0x48, 0x69) → writes (addr 0, 0x48) and (addr 1, 0x69); cursor (0,2); each wr_en 2 cycles after its rx_valid.
- Cursor at (0,5), send 0x08 → write (addr 4, 0x20), cursor (0,4); at col 0, 0x08 → no write, cursor unchanged.
- Cursor at (29,79), send 'A' → write addr 2399, cursor wraps to (0,0). With TERM_ROWCLEAR_EN, 80 writes of 0x20 to addr 0..79 follow.
- Send 0x0C → busy for 2400 cycles, wr_en on every cycle with addr 0..2399 and char 0x20, cursor (0,0). Bytes arriving meanwhile are processed afterwards in order.
- During CLEAR, send 6 bytes → first 4 are kept and processed, last 2 are dropped, overflow=1 and stays 1 until reset.
- Assert reset mid-CLEAR at addr 1000 → wr_en 0 immediately, cursor (0,0), busy 0, overflow 0.

Source files
------------

// File: rtl/term_pkg.sv
// Shared constants, FSM state type and screen address helper for the terminal writer.
// Geometry defaults match a 640x480 text mode with an 8x16 font.
package term_pkg;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;
    localparam int ADDR_W   = 12;

    localparam logic [7:0] CHR_BS       = 8'h08;
    localparam logic [7:0] CHR_LF       = 8'h0A;
    localparam logic [7:0] CHR_FF       = 8'h0C;
    localparam logic [7:0] CHR_CR       = 8'h0D;
    localparam logic [7:0] CHR_SPACE    = 8'h20;
    localparam logic [7:0] CHR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } state_t;

    // row*80 + col built from shifts; 29*80+79 = 2399 fits in 12 bits.
    function automatic logic [ADDR_W-1:0] rc_addr(input logic [4:0] row, input logic [6:0] col);
        logic [ADDR_W-1:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO: DEPTH entries (power of two), head visible combinationally on pop_dat.
// Latency: one cycle push-to-visible. Backpressure: push ignored when full unless popped in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/term_writer.sv
// Terminal writer: UART bytes -> cursor-tracked writes into the 80x30 character RAM (TERM_ROWCLEAR_EN blanks each new row).
// Latency: wr_en two cycles after rx_valid for a printable byte; FF/row clear emits one write per cycle.
// Backpressure: none upstream; bytes arriving on a full FIFO are dropped and flagged on sticky overflow.
module term_writer
    import term_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_char,
    output logic [4:0]        cursor_row,
    output logic [6:0]        cursor_col,
    output logic              busy,
    output logic              overflow
);

    localparam logic [6:0] SP = CHR_SPACE[6:0];

    state_t            state, state_n;
    logic [4:0]        row, row_n, row_inc;
    logic [6:0]        col, col_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W-1:0] clr_end, clr_end_n;
    logic [6:0]        char_q, char_n;
    logic              adv, adv_n;

    logic [7:0]        fifo_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;

    assign pop  = (state == IDLE) && !fifo_empty;
    assign push = rx_valid && (!fifo_full || pop);

    byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (rx_data),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // No scrolling: advancing past the last row wraps to the top.
    assign row_inc = (row == 5'(ROWS-1)) ? 5'd0 : row + 5'd1;

    always_comb begin
        state_n   = state;
        row_n     = row;
        col_n     = col;
        addr_n    = addr_q;
        char_n    = char_q;
        clr_end_n = clr_end;
        adv_n     = adv;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    if (fifo_dat >= CHR_PRINT_LO && fifo_dat <= CHR_PRINT_HI) begin
                        state_n = WRITE;
                        addr_n  = rc_addr(row, col);
                        char_n  = fifo_dat[6:0];
                        adv_n   = 1'b1;
                    end else begin
                        case (fifo_dat)
                            CHR_CR: col_n = 7'd0;
                            CHR_LF: begin
                                col_n = 7'd0;
                                row_n = row_inc;
`ifdef TERM_ROWCLEAR_EN
                                state_n   = CLEAR;
                                addr_n    = rc_addr(row_inc, 7'd0);
                                clr_end_n = rc_addr(row_inc, 7'd0) + ADDR_W'(COLS-1);
                                char_n    = SP;
`endif
                            end
                            CHR_BS: begin
                                if (col != 7'd0) begin
                                    col_n   = col - 7'd1;
                                    state_n = WRITE;
                                    addr_n  = rc_addr(row, col - 7'd1);
                                    char_n  = SP;
                                    adv_n   = 1'b0;
                                end
                            end
                            CHR_FF: begin
                                row_n     = 5'd0;
                                col_n     = 7'd0;
                                state_n   = CLEAR;
                                addr_n    = '0;
                                clr_end_n = ADDR_W'(COLS*ROWS-1);
                                char_n    = SP;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                state_n = IDLE;
                if (adv) begin
                    if (col == 7'(COLS-1)) begin
                        col_n = 7'd0;
                        row_n = row_inc;
`ifdef TERM_ROWCLEAR_EN
                        state_n   = CLEAR;
                        addr_n    = rc_addr(row_inc, 7'd0);
                        clr_end_n = rc_addr(row_inc, 7'd0) + ADDR_W'(COLS-1);
                        char_n    = SP;
`endif
                    end else begin
                        col_n = col + 7'd1;
                    end
                end
            end
            CLEAR: begin
                if (addr_q == clr_end) begin
                    state_n = IDLE;
                end else begin
                    addr_n = addr_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            addr_q   <= '0;
            char_q   <= '0;
            clr_end  <= '0;
            adv      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            col     <= col_n;
            addr_q  <= addr_n;
            char_q  <= char_n;
            clr_end <= clr_end_n;
            adv     <= adv_n;
            if (rx_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Writes are driven straight from state, so reset kills a write in flight.
    assign wr_en      = (state != IDLE);
    assign busy       = (state != IDLE);
    assign wr_addr    = addr_q;
    assign wr_char    = char_q;
    assign cursor_row = row;
    assign cursor_col = col;

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer in its default build: decode table, wrap, full clear with overflow, reset mid-clear.
module tb_term_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_char;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;
    logic        overflow;

    term_writer dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        wr;
        logic [11:0] addr;
        logic [6:0]  ch;
        logic [4:0]  row;
        logic [6:0]  col;
    } vec_t;

    vec_t        vecs [16];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] last_addr = 12'd0;
    logic [6:0]  last_char = 7'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the byte is fully handled.
    task automatic apply(input vec_t v, input string tag);
        rx_data  = v.b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk({tag, "_early"}, wr_en, 0);
        @(negedge clk);
        chk({tag, "_wr_en"}, wr_en, v.wr);
        if (v.wr) begin
            last_addr = v.addr;
            last_char = v.ch;
        end
        chk({tag, "_addr"}, wr_addr, last_addr);
        chk({tag, "_char"}, wr_char, last_char);
        @(negedge clk);
        chk({tag, "_row"}, cursor_row, v.row);
        chk({tag, "_col"}, cursor_col, v.col);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  inj [6];
        logic [11:0] got_addr [$];
        logic [6:0]  got_char [$];
        int          first_bad;
        int          wr_seen;
        bit          found;

        vecs[0]  = '{8'h48, 1'b1, 12'd0,  7'h48, 5'd0, 7'd1};
        vecs[1]  = '{8'h69, 1'b1, 12'd1,  7'h69, 5'd0, 7'd2};
        vecs[2]  = '{8'h61, 1'b1, 12'd2,  7'h61, 5'd0, 7'd3};
        vecs[3]  = '{8'h62, 1'b1, 12'd3,  7'h62, 5'd0, 7'd4};
        vecs[4]  = '{8'h63, 1'b1, 12'd4,  7'h63, 5'd0, 7'd5};
        vecs[5]  = '{8'h08, 1'b1, 12'd4,  7'h20, 5'd0, 7'd4};
        vecs[6]  = '{8'h0D, 1'b0, 12'd0,  7'h00, 5'd0, 7'd0};
        vecs[7]  = '{8'h08, 1'b0, 12'd0,  7'h00, 5'd0, 7'd0};
        vecs[8]  = '{8'h0A, 1'b0, 12'd0,  7'h00, 5'd1, 7'd0};
        vecs[9]  = '{8'h5A, 1'b1, 12'd80, 7'h5A, 5'd1, 7'd1};
        vecs[10] = '{8'h01, 1'b0, 12'd0,  7'h00, 5'd1, 7'd1};
        vecs[11] = '{8'h7F, 1'b0, 12'd0,  7'h00, 5'd1, 7'd1};
        vecs[12] = '{8'h7E, 1'b1, 12'd81, 7'h7E, 5'd1, 7'd2};
        vecs[13] = '{8'h20, 1'b1, 12'd82, 7'h20, 5'd1, 7'd3};
        vecs[14] = '{8'hC1, 1'b0, 12'd0,  7'h00, 5'd1, 7'd3};
        vecs[15] = '{8'h0A, 1'b0, 12'd0,  7'h00, 5'd2, 7'd0};

        inj[0] = 8'h61; inj[1] = 8'h62; inj[2] = 8'h63;
        inj[3] = 8'h64; inj[4] = 8'h65; inj[5] = 8'h66;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_char", wr_char, 0);
        chk("rst_row", cursor_row, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Walk to (29,79), then a printable byte wraps the cursor to the top.
        repeat (27) send(8'h0A);
        chk("pre_wrap_row", cursor_row, 29);
        repeat (79) send(8'h78);
        chk("pre_wrap_col", cursor_col, 79);
        apply('{8'h41, 1'b1, 12'd2399, 7'h41, 5'd0, 7'd0}, "wrap");
        chk("wrap_ovf", overflow, 0);

        apply('{8'h71, 1'b1, 12'd0, 7'h71, 5'd0, 7'd1}, "pre_ff");

        // Form feed: 2400 blanking writes, six bytes injected mid-clear.
        rx_data  = 8'h0C;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        first_bad = -1;
        for (int k = 0; k < 2400; k++) begin
            if (first_bad < 0 && (wr_en !== 1'b1 || busy !== 1'b1 || wr_addr !== 12'(k) ||
                                  wr_char !== 7'h20 || cursor_row !== 5'd0 || cursor_col !== 7'd0)) begin
                first_bad = k;
            end
            if (k >= 100 && k < 106) begin
                rx_data  = inj[k-100];
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("clear_first_bad_idx", first_bad, -1);
        chk("clear_done_wr_en", wr_en, 0);
        chk("clear_done_busy", busy, 0);

        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (wr_en) begin
                got_addr.push_back(wr_addr);
                got_char.push_back(wr_char);
            end
        end
        chk("post_clear_writes", got_addr.size(), 4);
        for (int j = 0; j < 4 && j < got_addr.size(); j++) begin
            chk($sformatf("post_clear_addr%0d", j), got_addr[j], j);
            chk($sformatf("post_clear_char%0d", j), got_char[j], 7'h61 + j);
        end
        chk("post_clear_row", cursor_row, 0);
        chk("post_clear_col", cursor_col, 4);
        chk("ovf_set", overflow, 1);
        repeat (20) @(negedge clk);
        chk("ovf_sticky", overflow, 1);

        // Reset in the middle of a clear, with bytes still queued.
        rx_data  = 8'h0C;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            if (wr_en === 1'b1 && wr_addr === 12'd1000) begin
                found = 1'b1;
            end else begin
                if (k == 5 || k == 6) begin
                    rx_data  = 8'h6D;
                    rx_valid = 1'b1;
                end else begin
                    rx_valid = 1'b0;
                end
                @(negedge clk);
            end
        end
        rx_valid = 1'b0;
        chk("reach_addr_1000", found, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_row", cursor_row, 0);
        chk("mid_rst_col", cursor_col, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_addr", wr_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        wr_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
        end
        chk("fifo_flushed_no_writes", wr_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
